// File: rtl/regfile_pkg.sv
// Shared sizing constants for the 16 x 32-bit general register file.
package regfile_pkg;
    localparam int                  RF_WIDTH    = 32;
    localparam int                  RF_NREGS    = 16;
    localparam int                  RF_IDX_W    = 4;
    localparam logic [RF_IDX_W-1:0] RF_PC_IDX   = 4'd15;
    localparam logic [RF_WIDTH-1:0] RF_PC_RESET = 32'h0000_0000;
endpackage

// File: rtl/dec_4x16_en.sv
// 4-to-16 one-hot decoder with enable; all-zero output while the enable is low.
module dec_4x16_en
    import regfile_pkg::*;
(
    input  logic                i_en,
    input  logic [RF_IDX_W-1:0] i_idx,
    output logic [RF_NREGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_write_16x32.sv
// Write side and storage of the 16-entry general register file; every register
// is presented in parallel straight from its flop for the external read muxes.
module reg_bank_write_16x32
    import regfile_pkg::*;
#(
    parameter int                  WIDTH    = RF_WIDTH,
    parameter logic [RF_IDX_W-1:0] PC_IDX   = RF_PC_IDX,
    parameter logic [WIDTH-1:0]    PC_RESET = RF_PC_RESET
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                LE_A,
    input  logic [RF_IDX_W-1:0] WA,
    input  logic [WIDTH-1:0]    DA,
    input  logic                LE_B,
    input  logic [RF_IDX_W-1:0] WB,
    input  logic [WIDTH-1:0]    DB,
    input  logic                PC_LE,
    input  logic [WIDTH-1:0]    PC_D,
    output logic [WIDTH-1:0]    Q0,
    output logic [WIDTH-1:0]    Q1,
    output logic [WIDTH-1:0]    Q2,
    output logic [WIDTH-1:0]    Q3,
    output logic [WIDTH-1:0]    Q4,
    output logic [WIDTH-1:0]    Q5,
    output logic [WIDTH-1:0]    Q6,
    output logic [WIDTH-1:0]    Q7,
    output logic [WIDTH-1:0]    Q8,
    output logic [WIDTH-1:0]    Q9,
    output logic [WIDTH-1:0]    Q10,
    output logic [WIDTH-1:0]    Q11,
    output logic [WIDTH-1:0]    Q12,
    output logic [WIDTH-1:0]    Q13,
    output logic [WIDTH-1:0]    Q14,
    output logic [WIDTH-1:0]    Q15,
    output logic                WR_CONF
);

    logic [RF_NREGS-1:0] w_sel_a;
    logic [RF_NREGS-1:0] w_sel_b;
    logic [WIDTH-1:0]    w_next [RF_NREGS];
    logic [WIDTH-1:0]    r_regs [RF_NREGS];
    logic                r_wr_conf;

    dec_4x16_en u_dec_a (
        .i_en     (LE_A),
        .i_idx    (WA),
        .o_onehot (w_sel_a)
    );

    dec_4x16_en u_dec_b (
        .i_en     (LE_B),
        .i_idx    (WB),
        .o_onehot (w_sel_b)
    );

    // Port A beats port B, and both beat the PC increment leg on the PC register.
    always_comb begin
        for (int n = 0; n < RF_NREGS; n++) begin
            w_next[n] = r_regs[n];
            if (w_sel_a[n]) begin
                w_next[n] = DA;
            end else if (w_sel_b[n]) begin
                w_next[n] = DB;
            end else if (PC_LE && (RF_IDX_W'(n) == PC_IDX)) begin
                w_next[n] = PC_D;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int n = 0; n < RF_NREGS; n++) begin
                r_regs[n] <= (RF_IDX_W'(n) == PC_IDX) ? PC_RESET : '0;
            end
            r_wr_conf <= 1'b0;
        end else begin
            for (int n = 0; n < RF_NREGS; n++) begin
                r_regs[n] <= w_next[n];
            end
            r_wr_conf <= LE_A && LE_B && (WA == WB);
        end
    end

    assign Q0      = r_regs[0];
    assign Q1      = r_regs[1];
    assign Q2      = r_regs[2];
    assign Q3      = r_regs[3];
    assign Q4      = r_regs[4];
    assign Q5      = r_regs[5];
    assign Q6      = r_regs[6];
    assign Q7      = r_regs[7];
    assign Q8      = r_regs[8];
    assign Q9      = r_regs[9];
    assign Q10     = r_regs[10];
    assign Q11     = r_regs[11];
    assign Q12     = r_regs[12];
    assign Q13     = r_regs[13];
    assign Q14     = r_regs[14];
    assign Q15     = r_regs[15];
    assign WR_CONF = r_wr_conf;

endmodule

// File: tb/tb_reg_bank_write_16x32.sv
// Directed bench for reg_bank_write_16x32: table of write vectors plus hand-written reset/hold sequences.
module tb_reg_bank_write_16x32;

    logic        Clk;
    logic        Rst_n;
    logic        LE_A;
    logic [3:0]  WA;
    logic [31:0] DA;
    logic        LE_B;
    logic [3:0]  WB;
    logic [31:0] DB;
    logic        PC_LE;
    logic [31:0] PC_D;
    logic [31:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic [31:0] Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15;
    logic        WR_CONF;

    logic [31:0] q [16];
    logic [31:0] shadow [16];
    int          n_chk;
    int          n_pass;

    typedef struct {
        logic        le_a;
        logic [3:0]  wa;
        logic [31:0] da;
        logic        le_b;
        logic [3:0]  wb;
        logic [31:0] db;
        logic        pc_le;
        logic [31:0] pc_d;
        logic [3:0]  i1;
        logic [31:0] v1;
        logic [3:0]  i2;
        logic [31:0] v2;
        logic        conf;
    } vec_t;

    localparam int NV = 23;
    vec_t tv [NV];

    reg_bank_write_16x32 dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .LE_A    (LE_A),
        .WA      (WA),
        .DA      (DA),
        .LE_B    (LE_B),
        .WB      (WB),
        .DB      (DB),
        .PC_LE   (PC_LE),
        .PC_D    (PC_D),
        .Q0      (Q0),
        .Q1      (Q1),
        .Q2      (Q2),
        .Q3      (Q3),
        .Q4      (Q4),
        .Q5      (Q5),
        .Q6      (Q6),
        .Q7      (Q7),
        .Q8      (Q8),
        .Q9      (Q9),
        .Q10     (Q10),
        .Q11     (Q11),
        .Q12     (Q12),
        .Q13     (Q13),
        .Q14     (Q14),
        .Q15     (Q15),
        .WR_CONF (WR_CONF)
    );

    assign q[0]  = Q0;
    assign q[1]  = Q1;
    assign q[2]  = Q2;
    assign q[3]  = Q3;
    assign q[4]  = Q4;
    assign q[5]  = Q5;
    assign q[6]  = Q6;
    assign q[7]  = Q7;
    assign q[8]  = Q8;
    assign q[9]  = Q9;
    assign q[10] = Q10;
    assign q[11] = Q11;
    assign q[12] = Q12;
    assign q[13] = Q13;
    assign q[14] = Q14;
    assign q[15] = Q15;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_conf);
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("%s Q%0d", tag, n), q[n], shadow[n]);
        end
        chk($sformatf("%s WR_CONF", tag), {31'd0, WR_CONF}, {31'd0, exp_conf});
    endtask

    task automatic idle_inputs();
        LE_A = 1'b0; WA = 4'd0; DA = 32'd0;
        LE_B = 1'b0; WB = 4'd0; DB = 32'd0;
        PC_LE = 1'b0; PC_D = 32'd0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;

        for (int n = 0; n < 16; n++) begin
            tv[n] = '{1'b1, 4'(n), 32'hA000_0000 | 32'(n), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0,
                      4'(n), 32'hA000_0000 | 32'(n), 4'(n), 32'hA000_0000 | 32'(n), 1'b0};
        end
        // distinct dual write
        tv[16] = '{1'b1, 4'd2, 32'h1111_1111, 1'b1, 4'd5, 32'h5555_5555, 1'b0, 32'd0,
                   4'd2, 32'h1111_1111, 4'd5, 32'h5555_5555, 1'b0};
        // collision: port A wins, flag raised
        tv[17] = '{1'b1, 4'd7, 32'hAAAA_AAAA, 1'b1, 4'd7, 32'hBBBB_BBBB, 1'b0, 32'd0,
                   4'd7, 32'hAAAA_AAAA, 4'd7, 32'hAAAA_AAAA, 1'b1};
        // idle: flag drops after one cycle
        tv[18] = '{1'b0, 4'd7, 32'h0, 1'b0, 4'd7, 32'h0, 1'b0, 32'd0,
                   4'd7, 32'hAAAA_AAAA, 4'd7, 32'hAAAA_AAAA, 1'b0};
        // port A to R15 beats PC increment
        tv[19] = '{1'b1, 4'd15, 32'h0000_2000, 1'b0, 4'd0, 32'd0, 1'b1, 32'h0000_0104,
                   4'd15, 32'h0000_2000, 4'd15, 32'h0000_2000, 1'b0};
        // PC increment alone
        tv[20] = '{1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h0000_2004,
                   4'd15, 32'h0000_2004, 4'd15, 32'h0000_2004, 1'b0};
        // port B to R15 beats PC increment
        tv[21] = '{1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h3000_0000, 1'b1, 32'h0000_2008,
                   4'd15, 32'h3000_0000, 4'd15, 32'h3000_0000, 1'b0};
        // port B alone into R0 (writable, no hard zero)
        tv[22] = '{1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'h0BAD_0000, 1'b0, 32'd0,
                   4'd0, 32'h0BAD_0000, 4'd0, 32'h0BAD_0000, 1'b0};

        // Reset overrides a simultaneous port A write
        idle_inputs();
        Rst_n = 1'b0;
        LE_A = 1'b1; WA = 4'd3; DA = 32'hFFFF_FFFF;
        tick();
        for (int n = 0; n < 16; n++) shadow[n] = 32'h0;
        chk_all("reset", 1'b0);

        Rst_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < NV; i++) begin
            LE_A = tv[i].le_a; WA = tv[i].wa; DA = tv[i].da;
            LE_B = tv[i].le_b; WB = tv[i].wb; DB = tv[i].db;
            PC_LE = tv[i].pc_le; PC_D = tv[i].pc_d;
            tick();
            shadow[tv[i].i2] = tv[i].v2;
            shadow[tv[i].i1] = tv[i].v1;
            chk_all($sformatf("vec%0d", i), tv[i].conf);
        end

        // Ten idle cycles: nothing may move
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_all($sformatf("idle%0d", c), 1'b0);
        end

        // Collision arms the flag, then reset on the next edge must clear it and discard writes
        LE_A = 1'b1; WA = 4'd9; DA = 32'h9999_AAAA;
        LE_B = 1'b1; WB = 4'd9; DB = 32'h9999_BBBB;
        tick();
        shadow[9] = 32'h9999_AAAA;
        chk_all("precoll", 1'b1);

        Rst_n = 1'b0;
        LE_A = 1'b1; WA = 4'd9; DA = 32'h1234_5678;
        LE_B = 1'b1; WB = 4'd9; DB = 32'h8765_4321;
        PC_LE = 1'b1; PC_D = 32'h0000_0400;
        tick();
        for (int n = 0; n < 16; n++) shadow[n] = 32'h0;
        chk_all("midreset", 1'b0);

        // Normal operation resumes after reset release
        Rst_n = 1'b1;
        idle_inputs();
        PC_LE = 1'b1; PC_D = 32'h0000_0004;
        tick();
        shadow[15] = 32'h0000_0004;
        chk_all("postreset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
